// File: rtl/mem_acc_pkg.sv
// Shared types and constants for the SRAM access controller: FSM encoding,
// access-direction constants and default bus widths.
package mem_acc_pkg;

    localparam int DATA_W_DEF = 256;
    localparam int ADDR_W_DEF = 7;
    localparam int CNT_W      = 8;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_ISSUE = 3'd1,
        ST_RD_WAIT  = 3'd2,
        ST_WR_WAIT  = 3'd3,
        ST_RESP     = 3'd4
    } accState_t;

endpackage

// File: rtl/mem_acc_cnt.sv
// Loadable down-counter with zero flag; shared between the read-latency wait
// and the write-timeout wait, which are never active together.
module mem_acc_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] loadVal,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= loadVal;
        else if (dec && count != '0)
            count <= count - 1'b1;
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// Core-side initiator for the 256-bit SRAM: one request at a time, registered
// memory strobes, single response per request. MEM_ACC_TIMEOUT_EN adds a write timeout.
module mem_access_ctrl
    import mem_acc_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int READ_LAT = 1,
    parameter int TIMEOUT  = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              MemEnable,
    output logic              MemReadWrite,
    output logic [ADDR_W-1:0] Address,
    output logic [DATA_W-1:0] DataIn,
    input  logic [DATA_W-1:0] DataOut,
    input  logic              WriteDone
);

    // Counter reaches zero on the edge where the wait must end.
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_LAT - 1);
    localparam logic [CNT_W-1:0] TO_LOAD = CNT_W'(TIMEOUT - 1);

    accState_t         state, stateNxt;
    logic              memEnNxt, rwNxt, respValidNxt, readyNxt;
    logic [ADDR_W-1:0] addrNxt;
    logic [DATA_W-1:0] dinNxt, rdataNxt;
    logic              cntLoad, cntDec, cntZero;
    logic [CNT_W-1:0]  cntLoadVal;
`ifdef MEM_ACC_TIMEOUT_EN
    logic              respErrNxt;
`endif

    mem_acc_cnt #(.W(CNT_W)) uCnt (
        .clk     (clk),
        .reset   (reset),
        .load    (cntLoad),
        .dec     (cntDec),
        .loadVal (cntLoadVal),
        .zero    (cntZero)
    );

    always_comb begin
        stateNxt     = state;
        memEnNxt     = MemEnable;
        rwNxt        = MemReadWrite;
        addrNxt      = Address;
        dinNxt       = DataIn;
        respValidNxt = resp_valid;
        rdataNxt     = resp_rdata;
`ifdef MEM_ACC_TIMEOUT_EN
        respErrNxt   = resp_err;
`endif
        cntLoad      = 1'b0;
        cntLoadVal   = '0;
        cntDec       = 1'b0;

        case (state)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    addrNxt  = req_addr;
                    rwNxt    = req_write;
                    memEnNxt = 1'b1;
                    if (req_write == MEM_WRITE) begin
                        dinNxt     = req_wdata;
                        cntLoad    = 1'b1;
                        cntLoadVal = TO_LOAD;
                        stateNxt   = ST_WR_WAIT;
                    end else begin
                        stateNxt = ST_RD_ISSUE;
                    end
                end
            end
            ST_RD_ISSUE: begin
                memEnNxt   = 1'b0;
                cntLoad    = 1'b1;
                cntLoadVal = RD_LOAD;
                stateNxt   = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (cntZero) begin
                    rdataNxt     = DataOut;
                    respValidNxt = 1'b1;
`ifdef MEM_ACC_TIMEOUT_EN
                    respErrNxt   = 1'b0;
`endif
                    stateNxt     = ST_RESP;
                end else begin
                    cntDec = 1'b1;
                end
            end
            ST_WR_WAIT: begin
                // WriteDone wins over an expiry on the same edge.
                if (WriteDone) begin
                    memEnNxt     = 1'b0;
                    rwNxt        = MEM_READ;
                    respValidNxt = 1'b1;
                    rdataNxt     = '0;
`ifdef MEM_ACC_TIMEOUT_EN
                    respErrNxt   = 1'b0;
`endif
                    stateNxt     = ST_RESP;
                end
`ifdef MEM_ACC_TIMEOUT_EN
                else if (cntZero) begin
                    memEnNxt     = 1'b0;
                    respValidNxt = 1'b1;
                    rdataNxt     = '0;
                    respErrNxt   = 1'b1;
                    stateNxt     = ST_RESP;
                end else begin
                    cntDec = 1'b1;
                end
`endif
            end
            ST_RESP: begin
                if (resp_ready) begin
                    respValidNxt = 1'b0;
                    stateNxt     = ST_IDLE;
                end
            end
            default: stateNxt = ST_IDLE;
        endcase

        readyNxt = (stateNxt == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            req_ready    <= 1'b0;
            MemEnable    <= 1'b0;
            MemReadWrite <= MEM_READ;
            Address      <= '0;
            DataIn       <= '0;
            resp_valid   <= 1'b0;
            resp_rdata   <= '0;
        end else begin
            state        <= stateNxt;
            req_ready    <= readyNxt;
            MemEnable    <= memEnNxt;
            MemReadWrite <= rwNxt;
            Address      <= addrNxt;
            DataIn       <= dinNxt;
            resp_valid   <= respValidNxt;
            resp_rdata   <= rdataNxt;
        end
    end

`ifdef MEM_ACC_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset)
            resp_err <= 1'b0;
        else
            resp_err <= respErrNxt;
    end
`else
    assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: SRAM pin model, request-level
// reference memory, table vectors, hand sequences and random traffic.
module tb_mem_access_ctrl;

    localparam int DW       = 256;
    localparam int AW       = 7;
    localparam int READ_LAT = 1;
    localparam int TIMEOUT  = 15;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0, req_ready, req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          resp_valid, resp_ready = 1'b0, resp_err;
    logic [DW-1:0] resp_rdata;
    logic          MemEnable, MemReadWrite;
    logic [AW-1:0] Address;
    logic [DW-1:0] DataIn, DataOut;
    logic          WriteDone;

    mem_access_ctrl #(.DATA_W(DW), .ADDR_W(AW), .READ_LAT(READ_LAT), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_err(resp_err),
        .MemEnable(MemEnable), .MemReadWrite(MemReadWrite), .Address(Address),
        .DataIn(DataIn), .DataOut(DataOut), .WriteDone(WriteDone)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Pin-level SRAM model, driven on the falling edge.
    logic [DW-1:0] memArr [128];
    bit            memInit = 1'b0;
    int            wrDly = -1;
    int            rdPend = 0;
    int            wrCnt = 0;
    logic [AW-1:0] rdA = '0;

    always @(negedge clk) begin
        if (!memInit) begin
            for (int i = 0; i < 128; i++) memArr[i] = '0;
            memInit = 1'b1;
        end
        if (rdPend > 0) begin
            rdPend--;
            DataOut = (rdPend == 0) ? memArr[rdA] : {8{$urandom}};
        end else begin
            DataOut = {8{$urandom}};
        end
        if (MemEnable === 1'b1 && MemReadWrite === 1'b0) begin
            rdPend = READ_LAT;
            rdA    = Address;
        end
        if (MemEnable === 1'b1 && MemReadWrite === 1'b1) begin
            wrCnt++;
            WriteDone = (wrDly >= 0 && wrCnt > wrDly);
            if (WriteDone) memArr[Address] = DataIn;
        end else begin
            wrCnt = 0;
            WriteDone = 1'($urandom_range(0, 1));
        end
    end

    // Request-level reference: what each location should hold.
    logic [DW-1:0] refMem [128];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic doTxn(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input int dly, input int hold, input bit busy,
                         input logic [DW-1:0] expR, input int expLat);
        int n;
        bit bad;
        n = 0;
        while (req_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("req_ready_idle", req_ready, 1'b1);
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; wrDly = dly;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("accept_en", MemEnable, 1'b1);
        chk("accept_rw", MemReadWrite, wr);
        chk("accept_addr", Address, a);
        chk("accept_ready", req_ready, 1'b0);
        if (wr) chk("accept_din", DataIn, d);
        n = 0;
        bad = 1'b0;
        while (resp_valid !== 1'b1 && n < 100) begin
            if (wr && (MemEnable !== 1'b1 || MemReadWrite !== 1'b1 || Address !== a || DataIn !== d))
                bad = 1'b1;
            if (!wr && n == 1) chk("rd_en_pulse", MemEnable, 1'b0);
            @(posedge clk); #1; n++;
        end
        chk("latency", n, expLat);
        if (wr) chk("wr_hold", bad, 1'b0);
        chk("rdata", resp_rdata, expR);
        chk("err", resp_err, 1'b0);
        chk("en_after", MemEnable, 1'b0);
        if (busy) begin
            req_valid = 1'b1; req_write = 1'b1; req_addr = 7'h11; req_wdata = 256'hB0B;
        end
        bad = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (resp_valid !== 1'b1 || resp_rdata !== expR || req_ready !== 1'b0 || MemEnable !== 1'b0)
                bad = 1'b1;
        end
        if (hold > 0) chk("resp_stable", bad, 1'b0);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("hs_valid", resp_valid, 1'b0);
        chk("hs_ready", req_ready, 1'b1);
        chk("hs_no_accept", MemEnable, 1'b0);
    endtask

    // Expected values from the reference memory and the latency rules.
    task automatic refTxn(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input int dly, input int hold, input bit busy);
        logic [DW-1:0] e;
        e = wr ? '0 : refMem[a];
        doTxn(wr, a, d, dly, hold, busy, e, wr ? dly + 1 : 1 + READ_LAT);
        if (wr) refMem[a] = d;
    endtask

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            dly;
        int            hold;
        logic [DW-1:0] expR;
        int            expLat;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int n;
        logic [DW-1:0] pat;
        vecs[0] = '{1'b1, 7'h05, 256'hAA,   2,  0, 256'h0,    3};
        vecs[1] = '{1'b1, 7'h05, 256'hAA00, 0,  0, 256'h0,    1};
        vecs[2] = '{1'b0, 7'h05, 256'h0,    0,  0, 256'hAA00, 2};
        vecs[3] = '{1'b1, 7'h7F, '1,        1,  0, 256'h0,    2};
        vecs[4] = '{1'b0, 7'h7F, 256'h0,    0,  1, '1,        2};
        vecs[5] = '{1'b1, 7'h00, 256'h1,    14, 0, 256'h0,   15};
        vecs[6] = '{1'b0, 7'h00, 256'h0,    0,  0, 256'h1,    2};
        vecs[7] = '{1'b0, 7'h05, 256'h0,    0,  3, 256'hAA00, 2};
        for (int i = 0; i < 128; i++) refMem[i] = '0;

        // Reset held two edges, then released.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", req_ready, 1'b0);
        chk("rst_en", MemEnable, 1'b0);
        chk("rst_rw", MemReadWrite, 1'b0);
        chk("rst_addr", Address, '0);
        chk("rst_din", DataIn, '0);
        chk("rst_rv", resp_valid, 1'b0);
        chk("rst_rdata", resp_rdata, '0);
        chk("rst_err", resp_err, 1'b0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_ready", req_ready, 1'b1);
        chk("post_rst_en", MemEnable, 1'b0);

        for (int i = 0; i < 8; i++) begin
            doTxn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].dly, vecs[i].hold, 1'b0,
                  vecs[i].expR, vecs[i].expLat);
            if (vecs[i].wr) refMem[vecs[i].addr] = vecs[i].wdata;
        end

        // Response backpressure with a competing request pending.
        refTxn(1'b1, 7'h10, 256'hC0FFEE, 1, 0, 1'b0);
        refTxn(1'b0, 7'h10, '0, 0, 5, 1'b1);
        refTxn(1'b1, 7'h11, 256'hB0B, 0, 0, 1'b0);
        refTxn(1'b0, 7'h11, '0, 0, 0, 1'b0);

        // Write that never completes.
        req_valid = 1'b1; req_write = 1'b1; req_addr = 7'h22; req_wdata = 256'h55; wrDly = -1;
        @(posedge clk); #1;
        req_valid = 1'b0;
`ifdef MEM_ACC_TIMEOUT_EN
        n = 0;
        while (resp_valid !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
        chk("to_latency", n, TIMEOUT);
        chk("to_err", resp_err, 1'b1);
        chk("to_rdata", resp_rdata, '0);
        chk("to_en", MemEnable, 1'b0);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("to_hs", req_ready, 1'b1);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 7'h22; req_wdata = 256'h55;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (5) @(posedge clk);
`else
        repeat (40) @(posedge clk);
`endif
        #1;
        chk("stall_rv", resp_valid, 1'b0);
        chk("stall_en", MemEnable, 1'b1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst_en", MemEnable, 1'b0);
        chk("midrst_rv", resp_valid, 1'b0);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_norsp", resp_valid, 1'b0);
        chk("midrst_ready", req_ready, 1'b1);

        // Address sweep: write a walking byte pattern, then read everything back.
        for (int a = 0; a < 128; a++) begin
            pat = 256'hAA << (8 * (a % 32));
            refTxn(1'b1, AW'(a), pat, a % 3, 0, 1'b0);
        end
        for (int a = 0; a < 128; a++) begin
            pat = 256'hAA << (8 * (a % 32));
            doTxn(1'b0, AW'(a), '0, 0, 0, 1'b0, pat, 1 + READ_LAT);
        end

        // Random traffic against the reference memory.
        for (int i = 0; i < 150; i++) begin
            refTxn(1'($urandom_range(0, 1)), AW'($urandom_range(0, 127)), {8{$urandom}},
                   int'($urandom_range(0, 5)), int'($urandom_range(0, 2)), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
